// File: rtl/rat_alu_flags.sv
// 8-bit ALU stage with registered carry/zero flags and an interrupt shadow copy.
// The result is combinational; cin is always the registered c_flag.
module rat_alu_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] alu_sel,
    input  logic       flg_c_ld,
    input  logic       flg_z_ld,
    input  logic       flg_c_set,
    input  logic       flg_c_clr,
    input  logic       flg_ld_sel,
    input  logic       flg_shad_ld,
    output logic [7:0] result,
    output logic       c_flag,
    output logic       z_flag
);

    logic [8:0] wide_s;
    logic       alu_c_s;
    logic       alu_z_s;
    logic       shad_c_r;
    logic       shad_z_r;

    // ALU datapath: result and next carry for the selected opcode
    always_comb begin
        wide_s  = 9'h000;
        result  = 8'h00;
        alu_c_s = 1'b0;
        case (alu_sel)
            4'd0: begin
                wide_s  = {1'b0, a} + {1'b0, b};
                result  = wide_s[7:0];
                alu_c_s = wide_s[8];
            end
            4'd1: begin
                wide_s  = {1'b0, a} + {1'b0, b} + {8'h00, c_flag};
                result  = wide_s[7:0];
                alu_c_s = wide_s[8];
            end
            // bit 8 of the 9-bit difference is the unsigned borrow
            4'd2, 4'd4: begin
                wide_s  = {1'b0, a} - {1'b0, b};
                result  = wide_s[7:0];
                alu_c_s = wide_s[8];
            end
            4'd3: begin
                wide_s  = {1'b0, a} - {1'b0, b} - {8'h00, c_flag};
                result  = wide_s[7:0];
                alu_c_s = wide_s[8];
            end
            4'd5:  result = a & b;
            4'd6:  result = a | b;
            4'd7:  result = a ^ b;
            4'd8:  result = a & b;
            4'd9: begin
                result  = {a[6:0], c_flag};
                alu_c_s = a[7];
            end
            4'd10: begin
                result  = {c_flag, a[7:1]};
                alu_c_s = a[0];
            end
            4'd11: begin
                result  = {a[6:0], a[7]};
                alu_c_s = a[7];
            end
            4'd12: begin
                result  = {a[0], a[7:1]};
                alu_c_s = a[0];
            end
            4'd13: begin
                result  = {a[7], a[7:1]};
                alu_c_s = a[0];
            end
            4'd14:   result = b;
            default: result = 8'h00;
        endcase
        alu_z_s = (result == 8'h00);
    end

    // Carry flag: clear beats set beats load
    always_ff @(posedge clk) begin
        if (rst) begin
            c_flag <= 1'b0;
        end else if (flg_c_clr) begin
            c_flag <= 1'b0;
        end else if (flg_c_set) begin
            c_flag <= 1'b1;
        end else if (flg_c_ld) begin
            c_flag <= flg_ld_sel ? shad_c_r : alu_c_s;
        end else begin
            c_flag <= c_flag;
        end
    end

    // Zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            z_flag <= 1'b0;
        end else if (flg_z_ld) begin
            z_flag <= flg_ld_sel ? shad_z_r : alu_z_s;
        end else begin
            z_flag <= z_flag;
        end
    end

    // Shadow copy samples the pre-edge flags, so save+restore on one edge swaps
    always_ff @(posedge clk) begin
        if (rst) begin
            shad_c_r <= 1'b0;
            shad_z_r <= 1'b0;
        end else if (flg_shad_ld) begin
            shad_c_r <= c_flag;
            shad_z_r <= z_flag;
        end else begin
            shad_c_r <= shad_c_r;
            shad_z_r <= shad_z_r;
        end
    end

endmodule

// File: doc/rat_alu_flags.md
# rat_alu_flags

Arithmetic/logic stage with carry and zero flag registers. It sits directly downstream of the 32 x 8-bit register file. Operand A comes from the X read port, and operand B comes from the Y read port or an immediate (the selection mux is external). The 8-bit result feeds back to the register-file write-data mux, and the flags feed the branch logic. The ALU datapath is combinational; the C/Z flags and their interrupt shadow copies are sequential.

## Interface
Parameters:
- none (datapath fixed at 8 bits; opcode width fixed at 4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  8  operand A (register file X output)
- b  in  8  operand B (register file Y output or immediate)
- alu_sel  in  4  operation select, encoding below
- flg_c_ld  in  1  load C flag from source selected by flg_ld_sel
- flg_z_ld  in  1  load Z flag from source selected by flg_ld_sel
- flg_c_set  in  1  force C to 1
- flg_c_clr  in  1  force C to 0
- flg_ld_sel  in  1  flag load source: 0 = ALU outputs, 1 = shadow flags
- flg_shad_ld  in  1  copy current C/Z into shadow registers
- result  out  8  combinational ALU result
- c_flag  out  1  registered carry flag; reset 0
- z_flag  out  1  registered zero flag; reset 0

## Operation
- The ALU carry-in `cin` is the internal registered `c_flag`; it is never taken from a port, so no combinational loop exists.
- Opcodes, given as result and next-C (alu_c):
  - 0 ADD: a+b; C = bit 8 of the 9-bit sum.
  - 1 ADDC: a+b+cin; C = bit 8.
  - 2 SUB: a-b; C = borrow (1 when a<b, unsigned).
  - 3 SUBC: a-b-cin; C = borrow.
  - 4 CMP: a-b, same as SUB. The result is produced, but the controller does not write it back.
  - 5 AND, 6 OR, 7 EXOR: bitwise; C = 0.
  - 8 TEST: a&b; C = 0.
  - 9 LSL: {a[6:0],cin}; C = a[7].
  - 10 LSR: {cin,a[7:1]}; C = a[0].
  - 11 ROL: {a[6:0],a[7]}; C = a[7].
  - 12 ROR: {a[0],a[7:1]}; C = a[0].
  - 13 ASR: {a[7],a[7:1]}; C = a[0].
  - 14 MOV: b; C = 0.
  - 15 reserved: result 8'h00; C = 0.
- alu_z = (result == 8'h00) for every opcode.
- All arithmetic is computed in 9 bits; the result is the low 8 bits.
- C register update, in priority order:
  - rst → 0
  - flg_c_clr → 0
  - flg_c_set → 1
  - flg_c_ld → (flg_ld_sel ? shad_c : alu_c)
  - otherwise hold
- Z register update:
  - rst → 0
  - flg_z_ld → (flg_ld_sel ? shad_z : alu_z)
  - otherwise hold
- Shadow registers (shad_c, shad_z):
  - rst → 0
  - flg_shad_ld → capture the pre-edge c_flag and z_flag
  - otherwise hold
- Shadow registers are internal and not exported.
- Simultaneous flg_shad_ld and a flag load or set/clear: the shadow captures the old value, and the flag takes the new value on the same edge.
- Simultaneous flg_shad_ld and flg_ld_sel restore: the flag receives the old shadow value, and the shadow receives the old flag value (a swap).

## Timing
- result depends combinationally on a, b, alu_sel and c_flag, with zero cycles of latency. It is valid in the same cycle the operands are valid.
- Flags update on the rising clk edge where the load/set/clr is asserted. They are visible one cycle later, including as cin for the next instruction.
- rst takes priority over every control input. During the reset cycle the ALU still computes, using cin = the current c_flag.
- After reset: c_flag = 0, z_flag = 0, shadows = 0, and result = f(a, b, alu_sel) with cin = 0.
- With no load/set/clr asserted, flags hold indefinitely regardless of ALU activity.
- Control inputs are level-sampled each edge. Holding flg_c_ld high for N cycles reloads C on every one of those N edges.

## Test plan
- Reset:
  - Stimulus: preload c=1, z=1, then assert rst for one edge with flg_c_set=1.
  - Required: c_flag=0 and z_flag=0 after the edge; ADD a=8'h00 b=8'h00 gives result 8'h00.
- Add/carry:
  - Stimulus: ADD a=8'hFF b=8'h01 with flg_c_ld=flg_z_ld=1.
  - Required: result 8'h00; after the edge c=1, z=1. The next ADDC a=8'h10 b=8'h05 gives result 8'h16.
- Subtract/compare:
  - SUB a=8'h05 b=8'h06 → result 8'hFF, c=1, z=0.
  - CMP a=8'h33 b=8'h33 → result 8'h00, c=0, z=1.
  - SUBC a=8'h10 b=8'h00 with c=1 → 8'h0F.
- Shifts with c=1:
  - LSL a=8'h81 → 8'h03, C=1.
  - LSR a=8'h02 → 8'h81, C=0.
  - ROR a=8'h01 → 8'h80, C=1.
  - ASR a=8'h80 → 8'hC0, C=0.
  - ROL a=8'h80 → 8'h01, C=1.
  - Sweep every opcode with a=8'hA5, b=8'h3C and check against a reference model, including opcode 15 → 8'h00.
- Shadow save/restore:
  - Stimulus: with c=1, z=0, assert flg_shad_ld and flg_c_clr on the same edge; then execute ADD a=b=0 with z load.
  - Required: c=0, z=1.
  - Stimulus: assert flg_ld_sel=flg_c_ld=flg_z_ld=1.
  - Required: c=1, z=0 restored.
- Priority/hold:
  - flg_c_set and flg_c_clr on the same edge → c=0.
  - flg_c_set with flg_c_ld where alu_c=0 → c=1.
  - Five cycles of varying ops with all loads low → c_flag and z_flag unchanged.
